// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: 5..DATA_WIDTH data bits, optional parity, 1/2 stop bits.
// Reports framing/parity/break/overrun and hands words out over a valid/ready port.
module uart_rx_cfg #(
  parameter int DIV_WIDTH     = 8,
  parameter int DATA_WIDTH    = 9,
  parameter int GLITCH_FILTER = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [3:0]            nbits,
  input  logic [2:0]            parity,
  input  logic                  stop2,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ferr,
  output logic                  o_perr,
  output logic                  o_brk,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_ovr
);

  localparam int         CW  = DIV_WIDTH + 1;
  localparam logic [4:0] DW5 = 5'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, STOP_2, DONE, WAIT_HI
  } state_t;

  state_t state, state_nx;

  logic [1:0] sync_q;
  logic       rx_s, rx_f, rx_q, fall;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  generate
    if (GLITCH_FILTER > 0) begin : g_flt
      logic [GLITCH_FILTER-1:0] flt_q;
      // Output only follows the line once GLITCH_FILTER samples agree.
      always_ff @(posedge clk) begin
        if (rst) begin
          flt_q <= '1;
          rx_f  <= 1'b1;
        end else begin
          flt_q <= (flt_q << 1) | GLITCH_FILTER'(rx_s);
          if (&flt_q)       rx_f <= 1'b1;
          else if (~|flt_q) rx_f <= 1'b0;
        end
      end
    end else begin : g_noflt
      assign rx_f = rx_s;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) rx_q <= 1'b1;
    else     rx_q <= rx_f;
  end
  assign fall = rx_q & ~rx_f;

  logic [CW-1:0] cnt;
  logic          ce, start_det, load;

  assign ce = cnt[CW-1];

  // First load lands ce mid start bit; reload with div gives div+2 clocks per bit.
  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (start_det) cnt <= {1'b0, div >> 1} - CW'(1);
    else if (ce)        cnt <= {1'b0, div};
    else                cnt <= cnt - CW'(1);
  end

  logic [4:0]            nb_cl, nb_l, bit_cnt;
  logic [2:0]            par_l;
  logic                  stop2_l;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  xor_acc, any_one, par_bit, ferr_acc, last_stop;
  logic                  perr, brk;

  always_comb begin
    nb_cl = {1'b0, nbits};
    if (nb_cl < 5'd5)      nb_cl = 5'd5;
    else if (nb_cl > DW5)  nb_cl = DW5;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE:    if (fall) begin
                 start_det = 1'b1;
                 state_nx  = START;
               end
      START:   if (ce) state_nx = rx_f ? IDLE : DATA;
      DATA:    if (ce && bit_cnt == nb_l - 5'd1) state_nx = par_l[2] ? PARITY : STOP;
      PARITY:  if (ce) state_nx = STOP;
      STOP:    if (ce) state_nx = stop2_l ? STOP_2 : DONE;
      STOP_2:  if (ce) state_nx = DONE;
      DONE:    begin
                 load     = 1'b1;
                 state_nx = last_stop ? IDLE : WAIT_HI;
               end
      WAIT_HI: if (rx_f) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nb_l      <= 5'd5;
      par_l     <= '0;
      stop2_l   <= 1'b0;
      data_r    <= '0;
      bit_cnt   <= '0;
      xor_acc   <= 1'b0;
      any_one   <= 1'b0;
      par_bit   <= 1'b0;
      ferr_acc  <= 1'b0;
      last_stop <= 1'b1;
    end else if (start_det) begin
      nb_l     <= nb_cl;
      par_l    <= parity;
      stop2_l  <= stop2;
      data_r   <= '0;
      bit_cnt  <= '0;
      xor_acc  <= 1'b0;
      any_one  <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (ce) begin
      case (state)
        DATA: begin
          data_r  <= data_r | (DATA_WIDTH'(rx_f) << bit_cnt);
          bit_cnt <= bit_cnt + 5'd1;
          xor_acc <= xor_acc ^ rx_f;
          any_one <= any_one | rx_f;
        end
        PARITY: begin
          par_bit <= rx_f;
          any_one <= any_one | rx_f;
        end
        STOP: begin
          ferr_acc  <= ferr_acc | ~rx_f;
          any_one   <= any_one | rx_f;
          last_stop <= rx_f;
        end
        STOP_2: begin
          ferr_acc  <= ferr_acc | ~rx_f;
          last_stop <= rx_f;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    perr = 1'b0;
    if (par_l[2]) begin
      case (par_l[1:0])
        2'b00:   perr = xor_acc ^ par_bit;
        2'b01:   perr = ~(xor_acc ^ par_bit);
        2'b10:   perr = ~par_bit;
        default: perr = par_bit;
      endcase
    end
  end
  assign brk = ~any_one;

  // A word completing while the previous one is still unaccepted is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ferr  <= 1'b0;
      o_perr  <= 1'b0;
      o_brk   <= 1'b0;
      o_ovr   <= 1'b0;
    end else begin
      o_ovr <= 1'b0;
      if (load) begin
        if (o_valid && !i_ready) begin
          o_ovr <= 1'b1;
        end else begin
          o_valid <= 1'b1;
          o_data  <= data_r;
          o_ferr  <= ferr_acc;
          o_perr  <= perr;
          o_brk   <= brk;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames push expected words, a monitor pops on handshake.
module tb_uart_rx_cfg;
  localparam int DW  = 9;
  localparam int BIT = 10;

  logic          clk = 1'b0;
  logic          rst, rx, stop2, i_ready;
  logic [7:0]    div;
  logic [3:0]    nbits;
  logic [2:0]    parity;
  logic [DW-1:0] o_data;
  logic          o_ferr, o_perr, o_brk, o_valid, o_ovr;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          ferr;
    logic          perr;
    logic          brk;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   ovr_seen = 0;

  uart_rx_cfg #(.DIV_WIDTH(8), .DATA_WIDTH(DW), .GLITCH_FILTER(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .div(div), .nbits(nbits), .parity(parity),
    .stop2(stop2), .o_data(o_data), .o_ferr(o_ferr), .o_perr(o_perr),
    .o_brk(o_brk), .o_valid(o_valid), .i_ready(i_ready), .o_ovr(o_ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_ovr) ovr_seen++;
      if (o_valid && i_ready) begin
        exp_t e;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data=%0h ferr=%0b perr=%0b brk=%0b, none expected",
                   o_data, o_ferr, o_perr, o_brk);
        end else begin
          e = q.pop_front();
          checks++;
          if (o_data !== e.d) begin
            errors++;
            $display("FAIL word_data: got %0h expected %0h", o_data, e.d);
          end
          checks++;
          if ({o_ferr, o_perr, o_brk} !== {e.ferr, e.perr, e.brk}) begin
            errors++;
            $display("FAIL word_flags(data %0h): got ferr/perr/brk=%b expected %b",
                     e.d, {o_ferr, o_perr, o_brk}, {e.ferr, e.perr, e.brk});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic f, input logic p, input logic b);
    exp_t e;
    e.d = d; e.ferr = f; e.perr = p; e.brk = b;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  // pm: 0 none, 1 even, 2 odd, 3 mark, 4 space
  task automatic send_frame(input logic [15:0] d, input int nb, input int pm,
                            input bit flip, input int ns, input bit bad_stop);
    logic        p;
    logic [15:0] m;
    m = (16'h1 << nb) - 16'h1;
    p = ^(d & m);
    case (pm)
      2:       p = ~p;
      3:       p = 1'b1;
      4:       p = 1'b0;
      default: ;
    endcase
    if (flip) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (pm != 0) send_bit(p);
    for (int i = 0; i < ns; i++) send_bit(!(bad_stop && i == 0));
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_low(input int n);
    rx = 1'b0;
    repeat (n) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic cfg(input logic [3:0] nb, input logic [2:0] par, input logic s2);
    nbits = nb; parity = par; stop2 = s2;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; i_ready = 1'b1; div = 8'd8;
    cfg(4'd8, 3'b000, 1'b0);
    repeat (5) @(negedge clk);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_data", 32'(o_data), 32'd0);
    chk("reset_flags", 32'({o_ferr, o_perr, o_brk}), 32'd0);
    chk("reset_ovr", 32'(o_ovr), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    push(9'h0A5, 0, 0, 0); send_frame(16'h0A5, 8, 0, 0, 1, 0);

    cfg(4'd7, 3'b100, 1'b1);
    push(9'h041, 0, 0, 0); send_frame(16'h041, 7, 1, 0, 2, 0);
    push(9'h041, 0, 1, 0); send_frame(16'h041, 7, 1, 1, 2, 0);

    cfg(4'd9, 3'b101, 1'b0);
    push(9'h1FF, 0, 0, 0); send_frame(16'h1FF, 9, 2, 0, 1, 0);

    cfg(4'd8, 3'b111, 1'b0);
    push(9'h03C, 0, 1, 0); send_frame(16'h03C, 8, 4, 1, 1, 0);
    cfg(4'd8, 3'b110, 1'b0);
    push(9'h0C3, 0, 1, 0); send_frame(16'h0C3, 8, 3, 1, 1, 0);
    push(9'h0C3, 0, 0, 0); send_frame(16'h0C3, 8, 3, 0, 1, 0);

    cfg(4'd3, 3'b000, 1'b0);
    push(9'h015, 0, 0, 0); send_frame(16'h015, 5, 0, 0, 1, 0);
    cfg(4'd15, 3'b000, 1'b0);
    push(9'h12B, 0, 0, 0); send_frame(16'h12B, 9, 0, 0, 1, 0);

    cfg(4'd8, 3'b000, 1'b0);
    push(9'h0A5, 1, 0, 0); send_frame(16'h0A5, 8, 0, 0, 1, 1);

    pulse_low(1);
    pulse_low(2);
    pulse_low(3);

    push(9'h000, 1, 0, 1);
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    push(9'h05A, 0, 0, 0); send_frame(16'h05A, 8, 0, 0, 1, 0);

    @(posedge clk); #1 i_ready = 1'b0;
    push(9'h011, 0, 0, 0); send_frame(16'h011, 8, 0, 0, 1, 0);
    send_frame(16'h022, 8, 0, 0, 1, 0);
    chk("held_data", 32'(o_data), 32'h011);
    chk("held_valid", 32'(o_valid), 32'd1);
    chk("ovr_pulse_count", 32'(ovr_seen), 32'd1);
    @(posedge clk); #1 i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("valid_dropped", 32'(o_valid), 32'd0);

    @(posedge clk); #1 i_ready = 1'b0;
    send_frame(16'h077, 8, 0, 0, 1, 0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rx = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    chk("rst_discard_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1 i_ready = 1'b1;
    repeat (20) @(negedge clk);
    push(9'h03C, 0, 0, 0); send_frame(16'h03C, 8, 0, 0, 1, 0);

    for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("ovr_total", 32'(ovr_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
